taxi_axis_pipeline_register: RTL and testbench

- Parametrised AXI4-Stream register slice chain. It is the registered successor of the combinational AXI4-Stream tie.
- Inserts LENGTH register stages between sink and source to break timing paths on tdata/tvalid and, in skid mode, on tready.
- Applies the same optional-signal gating as the tie: a disabled sideband on either side gives tie-off values at the output.
- Placed between MAC/PHY datapath blocks wherever a stream crosses a long route or a floorplan boundary.

---
 rtl/taxi_axis_pkg.sv | 26 ++
 rtl/taxi_axis_if.sv | 29 ++
 rtl/taxi_axis_register.sv | 99 +++++++++
 rtl/taxi_axis_pipeline_register.sv | 143 ++++++++++++++
 tb/tb_taxi_axis_pipeline_register.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/taxi_axis_pkg.sv
// Shared encodings and payload sizing for the AXI4-Stream register slice chain.
package taxi_axis_pkg;

   localparam int REG_BYPASS = 0;
   localparam int REG_SIMPLE = 1;
   localparam int REG_SKID   = 2;

   // Width of the flattened payload carrying only the sideband fields that survive gating.
   function automatic int taxi_axis_payload_w(
      input int data_w,
      input bit keep_en,
      input int keep_w,
      input bit strb_en,
      input bit last_en,
      input bit id_en,
      input int id_w,
      input bit dest_en,
      input int dest_w,
      input bit user_en,
      input int user_w
   );
      return data_w + (keep_en ? keep_w : 0) + (strb_en ? keep_w : 0) + (last_en ? 1 : 0)
         + (id_en ? id_w : 0) + (dest_en ? dest_w : 0) + (user_en ? user_w : 0);
   endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// AXI4-Stream interface; sideband presence and widths travel as interface parameters.
interface taxi_axis_if #(
   parameter int   DATA_W  = 8,
   parameter logic KEEP_EN = 1'b0,
   parameter int   KEEP_W  = (DATA_W + 7) / 8,
   parameter logic STRB_EN = 1'b0,
   parameter logic LAST_EN = 1'b1,
   parameter logic ID_EN   = 1'b0,
   parameter int   ID_W    = 8,
   parameter logic DEST_EN = 1'b0,
   parameter int   DEST_W  = 8,
   parameter logic USER_EN = 1'b0,
   parameter int   USER_W  = 1
);

   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic [KEEP_W-1:0] tstrb;
   logic              tlast;
   logic [ID_W-1:0]   tid;
   logic [DEST_W-1:0] tdest;
   logic [USER_W-1:0] tuser;
   logic              tvalid;
   logic              tready;

   modport src (output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, input tready);
   modport snk (input tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, output tready);

endinterface

// File: rtl/taxi_axis_register.sv
// One register slice on a flattened payload: bypass, simple register or full-throughput skid buffer.
module taxi_axis_register
   import taxi_axis_pkg::*;
#(
   parameter int REG_TYPE = REG_SKID,
   parameter int PL_W     = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PL_W-1:0] s_payload,
   input  logic            s_valid,
   output logic            s_ready,
   output logic [PL_W-1:0] m_payload,
   output logic            m_valid,
   input  logic            m_ready
);

   if (REG_TYPE == REG_SKID) begin : g_skid
      logic [PL_W-1:0] out_pl;
      logic [PL_W-1:0] tmp_pl;
      logic            out_valid;
      logic            tmp_valid;
      logic            s_ready_reg;
      logic            load_out;
      logic            load_tmp;
      logic            move_tmp;

      // Temp only fills while main is stalled; when upstream is blocked, draining temp wins.
      assign load_out = s_ready_reg && (m_ready || !out_valid);
      assign load_tmp = s_ready_reg && !m_ready && out_valid && s_valid;
      assign move_tmp = !s_ready_reg && m_ready;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            out_valid   <= 1'b0;
            tmp_valid   <= 1'b0;
            s_ready_reg <= 1'b0;
         end else begin
            s_ready_reg <= m_ready || (!tmp_valid && (!out_valid || !s_valid));
            if (load_out) begin
               out_valid <= s_valid;
            end else if (move_tmp) begin
               out_valid <= tmp_valid;
            end
            if (load_tmp) begin
               tmp_valid <= 1'b1;
            end else if (move_tmp) begin
               tmp_valid <= 1'b0;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (load_out) begin
            out_pl <= s_payload;
         end else if (move_tmp) begin
            out_pl <= tmp_pl;
         end
         if (load_tmp) begin
            tmp_pl <= s_payload;
         end
      end

      assign s_ready   = s_ready_reg;
      assign m_valid   = out_valid;
      assign m_payload = out_pl;
   end else if (REG_TYPE == REG_SIMPLE) begin : g_simple
      logic [PL_W-1:0] pl_reg;
      logic            valid_reg;

      assign s_ready = !valid_reg || m_ready;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_reg <= 1'b0;
         end else if (s_valid && s_ready) begin
            valid_reg <= 1'b1;
         end else if (m_ready) begin
            valid_reg <= 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (s_valid && s_ready) begin
            pl_reg <= s_payload;
         end
      end

      assign m_valid   = valid_reg;
      assign m_payload = pl_reg;
   end else begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = clk ^ rst_n;
      assign s_ready    = m_ready;
      assign m_valid    = s_valid;
      assign m_payload  = s_payload;
   end

endmodule

// File: rtl/taxi_axis_pipeline_register.sv
// AXI4-Stream register slice chain: LENGTH stages of one type, with tie-style sideband gating at the output.
module taxi_axis_pipeline_register
   import taxi_axis_pkg::*;
#(
   parameter int REG_TYPE = REG_SKID,
   parameter int LENGTH   = 2
) (
   input logic       clk,
   input logic       rst_n,
   taxi_axis_if.snk  s_axis,
   taxi_axis_if.src  m_axis
);

   localparam int   DATA_W  = s_axis.DATA_W;
   localparam logic KEEP_EN = s_axis.KEEP_EN && m_axis.KEEP_EN;
   localparam int   KEEP_W  = s_axis.KEEP_W;
   localparam logic STRB_EN = s_axis.STRB_EN && m_axis.STRB_EN;
   localparam logic LAST_EN = s_axis.LAST_EN && m_axis.LAST_EN;
   localparam logic ID_EN   = s_axis.ID_EN && m_axis.ID_EN;
   localparam int   ID_W    = s_axis.ID_W;
   localparam logic DEST_EN = s_axis.DEST_EN && m_axis.DEST_EN;
   localparam int   DEST_W  = s_axis.DEST_W;
   localparam logic USER_EN = s_axis.USER_EN && m_axis.USER_EN;
   localparam int   USER_W  = s_axis.USER_W;

   localparam int KEEP_OFFSET = DATA_W;
   localparam int STRB_OFFSET = KEEP_OFFSET + (KEEP_EN ? KEEP_W : 0);
   localparam int LAST_OFFSET = STRB_OFFSET + (STRB_EN ? KEEP_W : 0);
   localparam int ID_OFFSET   = LAST_OFFSET + (LAST_EN ? 1 : 0);
   localparam int DEST_OFFSET = ID_OFFSET + (ID_EN ? ID_W : 0);
   localparam int USER_OFFSET = DEST_OFFSET + (DEST_EN ? DEST_W : 0);
   localparam int PL_W = taxi_axis_payload_w(DATA_W, KEEP_EN, KEEP_W, STRB_EN, LAST_EN,
      ID_EN, ID_W, DEST_EN, DEST_W, USER_EN, USER_W);

   if (m_axis.DATA_W != s_axis.DATA_W) begin : g_chk_data
      $fatal(1, "taxi_axis_pipeline_register: DATA_W differs between s_axis and m_axis");
   end
   if (KEEP_EN && (m_axis.KEEP_W != s_axis.KEEP_W)) begin : g_chk_keep
      $fatal(1, "taxi_axis_pipeline_register: KEEP_W differs between s_axis and m_axis");
   end
   if (REG_TYPE > REG_SKID) begin : g_chk_type
      $fatal(1, "taxi_axis_pipeline_register: REG_TYPE must be 0, 1 or 2");
   end

   logic [PL_W-1:0]   pl_in;
   logic [PL_W-1:0]   pl_out;
   logic [KEEP_W-1:0] keep_out;
   logic              unused_sideband;

   // Disabled fields still exist on the sink interface but never reach storage.
   assign unused_sideband = ^{s_axis.tkeep, s_axis.tstrb, s_axis.tlast, s_axis.tid,
      s_axis.tdest, s_axis.tuser};

   assign pl_in[DATA_W-1:0] = s_axis.tdata;
   if (KEEP_EN) begin : g_keep_in
      assign pl_in[KEEP_OFFSET +: KEEP_W] = s_axis.tkeep;
   end
   if (STRB_EN) begin : g_strb_in
      assign pl_in[STRB_OFFSET +: KEEP_W] = s_axis.tstrb;
   end
   if (LAST_EN) begin : g_last_in
      assign pl_in[LAST_OFFSET] = s_axis.tlast;
   end
   if (ID_EN) begin : g_id_in
      assign pl_in[ID_OFFSET +: ID_W] = s_axis.tid;
   end
   if (DEST_EN) begin : g_dest_in
      assign pl_in[DEST_OFFSET +: DEST_W] = s_axis.tdest;
   end
   if (USER_EN) begin : g_user_in
      assign pl_in[USER_OFFSET +: USER_W] = s_axis.tuser;
   end

   if (REG_TYPE == REG_BYPASS || LENGTH == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl    = clk ^ rst_n;
      assign pl_out        = pl_in;
      assign m_axis.tvalid = s_axis.tvalid;
      assign s_axis.tready = m_axis.tready;
   end else begin : g_chain
      logic [PL_W-1:0] pl_chain  [0:LENGTH];
      logic            vld_chain [0:LENGTH];
      logic            rdy_chain [0:LENGTH];

      assign pl_chain[0]       = pl_in;
      assign vld_chain[0]      = s_axis.tvalid;
      assign s_axis.tready     = rdy_chain[0];
      assign rdy_chain[LENGTH] = m_axis.tready;

      for (genvar i = 0; i < LENGTH; i++) begin : g_stage
         taxi_axis_register #(
            .REG_TYPE (REG_TYPE),
            .PL_W     (PL_W)
         ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .s_payload (pl_chain[i]),
            .s_valid   (vld_chain[i]),
            .s_ready   (rdy_chain[i]),
            .m_payload (pl_chain[i+1]),
            .m_valid   (vld_chain[i+1]),
            .m_ready   (rdy_chain[i+1])
         );
      end

      assign pl_out        = pl_chain[LENGTH];
      assign m_axis.tvalid = vld_chain[LENGTH];
   end

   assign m_axis.tdata = pl_out[DATA_W-1:0];
   if (KEEP_EN) begin : g_keep_out
      assign keep_out = pl_out[KEEP_OFFSET +: KEEP_W];
   end else begin : g_keep_tie
      assign keep_out = '1;
   end
   assign m_axis.tkeep = keep_out;
   if (STRB_EN) begin : g_strb_out
      assign m_axis.tstrb = pl_out[STRB_OFFSET +: KEEP_W];
   end else begin : g_strb_tie
      assign m_axis.tstrb = keep_out;
   end
   if (LAST_EN) begin : g_last_out
      assign m_axis.tlast = pl_out[LAST_OFFSET];
   end else begin : g_last_tie
      assign m_axis.tlast = 1'b1;
   end
   if (ID_EN) begin : g_id_out
      assign m_axis.tid = pl_out[ID_OFFSET +: ID_W];
   end else begin : g_id_tie
      assign m_axis.tid = '0;
   end
   if (DEST_EN) begin : g_dest_out
      assign m_axis.tdest = pl_out[DEST_OFFSET +: DEST_W];
   end else begin : g_dest_tie
      assign m_axis.tdest = '0;
   end
   if (USER_EN) begin : g_user_out
      assign m_axis.tuser = pl_out[USER_OFFSET +: USER_W];
   end else begin : g_user_tie
      assign m_axis.tuser = '0;
   end

endmodule

// File: tb/tb_taxi_axis_pipeline_register.sv
// Scoreboard bench for the AXI4-Stream register slice chain across several stage configurations.
module tb_taxi_axis_pipeline_register;

   typedef struct {
      logic [63:0] data;
      logic [36:0] side;
      int          cyc;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          sel = 0;
   int          cyc = 0;
   int          mready_mode = 1;
   logic        drv_valid = 1'b0;
   logic [63:0] drv_data = '0;
   logic [7:0]  drv_keep = '0;
   logic        drv_last = 1'b0;
   logic [7:0]  drv_id = '0;
   logic [7:0]  drv_dest = '0;
   logic [3:0]  drv_user = '0;
   logic        drv_mready = 1'b1;
   logic        mon_en = 1'b0;
   logic        lat_chk = 1'b0;
   int          lat_exp = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   beat_t       sb[$];
   beat_t       mon_e;

   logic [102:0] obs_bus;
   logic         obs_valid, obs_last, obs_s_ready;
   logic [63:0]  obs_data;
   logic [7:0]   obs_keep, obs_strb, obs_id, obs_dest;
   logic [3:0]   obs_user;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   taxi_axis_if #(.DATA_W(64), .KEEP_EN(1), .KEEP_W(8), .STRB_EN(0), .LAST_EN(1), .ID_EN(1),
      .ID_W(8), .DEST_EN(1), .DEST_W(8), .USER_EN(1), .USER_W(4))
      s_a(), m_a(), s_b(), m_b(), s_c(), m_c(), s_d(), m_d();
   taxi_axis_if #(.DATA_W(64), .KEEP_EN(1), .KEEP_W(8), .STRB_EN(0), .LAST_EN(0), .ID_EN(0),
      .ID_W(8), .DEST_EN(0), .DEST_W(8), .USER_EN(1), .USER_W(4)) s_e();
   taxi_axis_if #(.DATA_W(64), .KEEP_EN(0), .KEEP_W(8), .STRB_EN(0), .LAST_EN(1), .ID_EN(0),
      .ID_W(8), .DEST_EN(0), .DEST_W(8), .USER_EN(1), .USER_W(4)) m_e();

   taxi_axis_pipeline_register #(.REG_TYPE(2), .LENGTH(2)) dut_a (.clk(clk), .rst_n(rst_n), .s_axis(s_a), .m_axis(m_a));
   taxi_axis_pipeline_register #(.REG_TYPE(1), .LENGTH(2)) dut_b (.clk(clk), .rst_n(rst_n), .s_axis(s_b), .m_axis(m_b));
   taxi_axis_pipeline_register #(.REG_TYPE(2), .LENGTH(3)) dut_c (.clk(clk), .rst_n(rst_n), .s_axis(s_c), .m_axis(m_c));
   taxi_axis_pipeline_register #(.REG_TYPE(0), .LENGTH(2)) dut_d (.clk(clk), .rst_n(rst_n), .s_axis(s_d), .m_axis(m_d));
   taxi_axis_pipeline_register #(.REG_TYPE(2), .LENGTH(1)) dut_e (.clk(clk), .rst_n(rst_n), .s_axis(s_e), .m_axis(m_e));

   assign s_a.tvalid = drv_valid && (sel == 0);
   assign {s_a.tdata, s_a.tkeep, s_a.tstrb, s_a.tlast, s_a.tid, s_a.tdest, s_a.tuser} = {drv_data, drv_keep, drv_keep, drv_last, drv_id, drv_dest, drv_user};
   assign m_a.tready = drv_mready;
   assign s_b.tvalid = drv_valid && (sel == 1);
   assign {s_b.tdata, s_b.tkeep, s_b.tstrb, s_b.tlast, s_b.tid, s_b.tdest, s_b.tuser} = {drv_data, drv_keep, drv_keep, drv_last, drv_id, drv_dest, drv_user};
   assign m_b.tready = drv_mready;
   assign s_c.tvalid = drv_valid && (sel == 2);
   assign {s_c.tdata, s_c.tkeep, s_c.tstrb, s_c.tlast, s_c.tid, s_c.tdest, s_c.tuser} = {drv_data, drv_keep, drv_keep, drv_last, drv_id, drv_dest, drv_user};
   assign m_c.tready = drv_mready;
   assign s_d.tvalid = drv_valid && (sel == 3);
   assign {s_d.tdata, s_d.tkeep, s_d.tstrb, s_d.tlast, s_d.tid, s_d.tdest, s_d.tuser} = {drv_data, drv_keep, drv_keep, drv_last, drv_id, drv_dest, drv_user};
   assign m_d.tready = drv_mready;
   assign s_e.tvalid = drv_valid && (sel == 4);
   assign {s_e.tdata, s_e.tkeep, s_e.tstrb, s_e.tlast, s_e.tid, s_e.tdest, s_e.tuser} = {drv_data, drv_keep, drv_keep, drv_last, drv_id, drv_dest, drv_user};
   assign m_e.tready = drv_mready;

   always_comb begin
      obs_bus = '0;
      case (sel)
         0: obs_bus = {m_a.tvalid, m_a.tdata, m_a.tkeep, m_a.tstrb, m_a.tlast, m_a.tid, m_a.tdest, m_a.tuser, s_a.tready};
         1: obs_bus = {m_b.tvalid, m_b.tdata, m_b.tkeep, m_b.tstrb, m_b.tlast, m_b.tid, m_b.tdest, m_b.tuser, s_b.tready};
         2: obs_bus = {m_c.tvalid, m_c.tdata, m_c.tkeep, m_c.tstrb, m_c.tlast, m_c.tid, m_c.tdest, m_c.tuser, s_c.tready};
         3: obs_bus = {m_d.tvalid, m_d.tdata, m_d.tkeep, m_d.tstrb, m_d.tlast, m_d.tid, m_d.tdest, m_d.tuser, s_d.tready};
         default: obs_bus = {m_e.tvalid, m_e.tdata, m_e.tkeep, m_e.tstrb, m_e.tlast, m_e.tid, m_e.tdest, m_e.tuser, s_e.tready};
      endcase
   end
   assign {obs_valid, obs_data, obs_keep, obs_strb, obs_last, obs_id, obs_dest, obs_user, obs_s_ready} = obs_bus;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Gating instance: keep/strb tie to ones, last ties high, id/dest tie to zero, user passes.
   function automatic logic [36:0] exp_side(input int s, input logic [7:0] k, input logic l,
                                            input logic [7:0] id, input logic [7:0] d, input logic [3:0] u);
      if (s == 4) return {8'hff, 8'hff, 1'b1, 8'h00, 8'h00, u};
      return {k, k, l, id, d, u};
   endfunction

   always @(posedge clk) begin
      #1;
      case (mready_mode)
         0: drv_mready = 1'b0;
         1: drv_mready = 1'b1;
         default: drv_mready = ($urandom_range(99) < 50);
      endcase
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (drv_valid && obs_s_ready)
            sb.push_back('{drv_data, exp_side(sel, drv_keep, drv_last, drv_id, drv_dest, drv_user), cyc});
         if (obs_valid && drv_mready) begin
            if (sb.size() == 0) begin
               chk_eq("spurious_beat", 64'd1, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               chk_eq("beat_data", obs_data, mon_e.data);
               chk_eq("beat_side", 64'({obs_keep, obs_strb, obs_last, obs_id, obs_dest, obs_user}), 64'(mon_e.side));
               if (lat_chk) chk_eq("latency", 64'(cyc - mon_e.cyc), 64'(lat_exp));
            end
         end
      end
   end

   task automatic send(input int n, input int gap_pct, input bit seq_data);
      bit hs;
      int waitc;
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(99) < gap_pct) begin
            drv_valid = 1'b0;
            @(posedge clk); #1;
         end
         drv_valid = 1'b1;
         drv_data  = seq_data ? 64'(i) : {$urandom, $urandom};
         drv_keep  = 8'($urandom);
         drv_last  = 1'($urandom);
         drv_id    = 8'($urandom);
         drv_dest  = 8'($urandom);
         drv_user  = 4'($urandom);
         hs = 1'b0;
         waitc = 0;
         while (!hs && waitc < 2000) begin
            @(negedge clk);
            hs = obs_s_ready;
            @(posedge clk); #1;
            waitc++;
         end
         if (!hs) begin
            chk_eq("handshake_timeout", 64'd0, 64'd1);
            break;
         end
      end
      drv_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk_eq({"drain_", tag}, 64'(sb.size()), 64'd0);
   endtask

   task automatic fill(input int n_cycles, output int acc);
      acc = 0;
      drv_valid = 1'b1;
      for (int i = 0; i < n_cycles; i++) begin
         drv_data = 64'(100 + acc);
         @(negedge clk);
         if (obs_s_ready) acc++;
         @(posedge clk); #1;
      end
      drv_valid = 1'b0;
   endtask

   initial begin
      int acc;
      int t0;
      logic [63:0] byp_val;
      drv_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         chk_eq("rst_m_tvalid", 64'(obs_valid), 64'd0);
         chk_eq("rst_s_tready", 64'(obs_s_ready), 64'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      drv_valid = 1'b0;
      @(posedge clk); #1;
      chk_eq("ready_after_release", 64'(obs_s_ready), 64'd1);
      mon_en = 1'b1;

      lat_chk = 1'b1;
      lat_exp = 2;
      t0 = cyc;
      send(16, 0, 1'b1);
      chk_eq("stream_cycles", 64'(cyc - t0), 64'd16);
      drain("stream");
      lat_chk = 1'b0;

      for (int s = 0; s < 2; s++) begin
         sel = s;
         mready_mode = 0;
         @(posedge clk); #1;
         @(posedge clk); #1;
         fill(20, acc);
         chk_eq(s == 0 ? "skid_capacity" : "simple_capacity", 64'(acc), s == 0 ? 64'd4 : 64'd2);
         chk_eq("capacity_ready_low", 64'(obs_s_ready), 64'd0);
         mready_mode = 1;
         drain("capacity");
      end

      for (int s = 0; s < 2; s++) begin
         sel = s;
         mready_mode = 2;
         send(1000, 30, 1'b0);
         mready_mode = 1;
         drain("random");
      end

      sel = 4;
      send(8, 0, 1'b0);
      drain("gating");

      sel = 3;
      for (int i = 0; i < 4; i++) begin
         mready_mode = i % 2;
         @(posedge clk); #2;
         byp_val = {$urandom, $urandom};
         drv_valid = 1'b1;
         drv_data = byp_val;
         #1;
         chk_eq("bypass_valid", 64'(obs_valid), 64'd1);
         chk_eq("bypass_data", obs_data, byp_val);
         chk_eq("bypass_ready", 64'(obs_s_ready), 64'(i % 2));
         drv_valid = 1'b0;
      end
      mready_mode = 1;
      drain("bypass");

      sel = 2;
      mready_mode = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      send(3, 0, 1'b1);
      @(negedge clk);
      chk_eq("held_before_reset", 64'(obs_valid), 64'd1);
      @(posedge clk); #1;
      mon_en = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_eq("midreset_m_tvalid", 64'(obs_valid), 64'd0);
      chk_eq("midreset_s_tready", 64'(obs_s_ready), 64'd0);
      sb.delete();
      rst_n = 1'b1;
      mready_mode = 1;
      mon_en = 1'b1;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (obs_valid) acc++;
         @(posedge clk); #1;
      end
      chk_eq("no_stale_beat", 64'(acc), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
